ps2_kbd_event_rx: RTL



---
 rtl/ps2_kbd_event_rx.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd_event_rx.sv
// PS/2 keyboard front end: pin synchronisers, clock glitch filter, frame
// deframer with parity/stop/timeout checking, E0/F0 prefix decoder and a
// first-word-fall-through event FIFO with a valid/ready handshake.
module ps2_kbd_event_rx #(
    parameter int FILTER_SIZE    = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8,
    parameter int CW             = $clog2(FIFO_DEPTH+1)
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          kbd_clk,
    input  logic          kbd_dat,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic [8:0]    evt_code,
    output logic          evt_make,
    output logic [CW-1:0] fifo_count,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic          err_pulse,
    output logic [7:0]    err_cnt
);
    localparam int FCW = $clog2(FILTER_SIZE+1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES+1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [FCW-1:0] FLT_LAST = FCW'(FILTER_SIZE-1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  DEPTH_C  = CW'(FIFO_DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic           sample;
    logic [1:0]     state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           byte_stb_q, byte_stb_d;
    logic           frame_err;
    logic           ext_q, ext_d, brk_q, brk_d;
    logic           push_q, push_d;
    logic [9:0]     push_data_q, push_data_d;
    logic           err_pulse_q, err_pulse_d;
    logic [7:0]     err_cnt_q, err_cnt_d;
    logic [9:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [9:0]     last_q, last_d;
    logic [9:0]     head;
    logic           pop, full, wr_en, drop;

    // Glitch filter: flip filtered clock only after FILTER_SIZE differing samples
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FLT_LAST) filt_d     = ~filt_q;
            else                        filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    // A sample is taken on the cycle the filtered clock falls
    assign sample = filt_q & ~filt_d;

    // Frame deframer with per-bit timeout while a frame is in progress
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        byte_stb_d = 1'b0;
        frame_err  = 1'b0;
        if (sample) begin
            tmo_d = '0;
            case (state_q)
                IDLE: if (!dat_s2_q) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
                DATA: begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                default: begin
                    if (dat_s2_q && (^{shift_q, par_q})) byte_stb_d = 1'b1;
                    else                                 frame_err  = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end else if (state_q != IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d   = IDLE;
                tmo_d     = '0;
                frame_err = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Prefix decoder and error bookkeeping; errors drop any pending prefix
    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        if (byte_stb_q) begin
            case (shift_q)
                8'hE0:   ext_d = 1'b1;
                8'hF0:   brk_d = 1'b1;
                default: begin
                    push_d      = 1'b1;
                    push_data_d = {~brk_q, ext_q, shift_q};
                    ext_d       = 1'b0;
                    brk_d       = 1'b0;
                end
            endcase
        end
        if (frame_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
        err_pulse_d = frame_err;
        err_cnt_d   = (frame_err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    // FIFO control: pops need a stored head, a full push survives only with a pop
    always_comb begin
        pop      = (count_q != '0) && evt_ready;
        full     = (count_q == DEPTH_C);
        wr_en    = push_q && (!full || pop);
        drop     = push_q && full && !pop;
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d  = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        head   = mem_q[rd_ptr_q];
        last_d = (count_q != '0) ? head : last_q;
    end

    // State registers; everything idles high / empty out of reset
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= IDLE;
            idx_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            byte_stb_q  <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            last_q      <= '0;
        end else begin
            clk_s1_q    <= kbd_clk;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= kbd_dat;
            dat_s2_q    <= dat_s1_q;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            byte_stb_q  <= byte_stb_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            last_q      <= last_d;
        end
    end

    // Event storage; contents only matter once counted, so no reset
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data_q;
    end

    assign evt_valid            = (count_q != '0);
    assign {evt_make, evt_code} = evt_valid ? head : last_q;
    assign fifo_count           = count_q;
    assign overflow             = ovf_q;
    assign err_pulse            = err_pulse_q;
    assign err_cnt              = err_cnt_q;
endmodule
